// File: rtl/clock_set_controller.sv
// Front-panel sequencing for the hour/minute/second counter chain: run/set modes,
// per-field inc/dec pulses, held-button auto-repeat, idle timeout and blink strobe.
module clock_set_controller #(
  parameter int TIMEOUT_TICKS = 30,
  parameter int REPEAT_DELAY  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       count_en,
  output logic [2:0] inc_pulse,
  output logic [2:0] dec_pulse,
  output logic [1:0] field_sel,
  output logic       set_active,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_SAT  = 4'(REPEAT_DELAY);
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_TICKS - 1);

  state_t     state_reg, state_next;

  // Button vector: bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0] btn_raw;
  logic [2:0] btn_s_reg, btn_q_reg, btn_edge;
  logic       tick_reg;

  logic [3:0] hold_reg, hold_next;
  logic [7:0] idle_reg, idle_next;
  logic       count_en_reg, count_en_next;
  logic [2:0] inc_reg, inc_next;
  logic [2:0] dec_reg, dec_next;
  logic [1:0] field_sel_reg, field_sel_next;
  logic       set_active_reg, set_active_next;
  logic       blink_reg, blink_next;

  logic [2:0] field_mask;
  logic       mode_edge, up_edge, down_edge;
  logic       up_s, down_s, one_held, any_held;
  logic       pair_conflict, repeat_fire, timeout;

  assign btn_raw = {btn_down, btn_up, btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign btn_edge[gi] = btn_s_reg[gi] & ~btn_q_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      btn_s_reg      <= 3'b000;
      btn_q_reg      <= 3'b000;
      tick_reg       <= 1'b0;
      hold_reg       <= 4'd0;
      idle_reg       <= 8'd0;
      count_en_reg   <= 1'b0;
      inc_reg        <= 3'b000;
      dec_reg        <= 3'b000;
      field_sel_reg  <= 2'd0;
      set_active_reg <= 1'b0;
      blink_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      btn_s_reg      <= btn_raw;
      btn_q_reg      <= btn_s_reg;
      tick_reg       <= tick_1hz;
      hold_reg       <= hold_next;
      idle_reg       <= idle_next;
      count_en_reg   <= count_en_next;
      inc_reg        <= inc_next;
      dec_reg        <= dec_next;
      field_sel_reg  <= field_sel_next;
      set_active_reg <= set_active_next;
      blink_reg      <= blink_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_en_next = 1'b0;
    inc_next      = 3'b000;
    dec_next      = 3'b000;
    hold_next     = hold_reg;
    idle_next     = idle_reg;
    blink_next    = blink_reg;
    field_mask    = 3'b000;

    mode_edge     = btn_edge[0];
    up_edge       = btn_edge[1];
    down_edge     = btn_edge[2];
    up_s          = btn_s_reg[1];
    down_s        = btn_s_reg[2];
    one_held      = up_s ^ down_s;
    any_held      = |btn_s_reg;
    pair_conflict = (up_edge | down_edge) & up_s & down_s;
    repeat_fire   = tick_reg & one_held & (hold_reg == HOLD_SAT);
    timeout       = tick_reg & ~any_held & (idle_reg == IDLE_LAST);

    case (state_reg)
      SET_HOUR: field_mask = 3'b100;
      SET_MIN:  field_mask = 3'b010;
      SET_SEC:  field_mask = 3'b001;
      default:  field_mask = 3'b000;
    endcase

    if (state_reg == RUN) begin
      count_en_next = tick_reg;
      hold_next     = 4'd0;
      idle_next     = 8'd0;
      blink_next    = 1'b0;
      if (mode_edge) state_next = SET_HOUR;
    end else begin
      if (mode_edge) begin
        case (state_reg)
          SET_HOUR: state_next = SET_MIN;
          SET_MIN:  state_next = SET_SEC;
          default:  state_next = RUN;
        endcase
      end else if (timeout) begin
        state_next = RUN;
      end

      // Mode edges and up/down collisions suppress every edit pulse
      if (!mode_edge && !pair_conflict) begin
        if ((up_edge & ~down_s) | (repeat_fire & up_s))   inc_next = field_mask;
        if ((down_edge & ~up_s) | (repeat_fire & down_s)) dec_next = field_mask;
      end

      if (mode_edge || pair_conflict || !one_held)
        hold_next = 4'd0;
      else if (tick_reg && hold_reg < HOLD_SAT)
        hold_next = hold_reg + 4'd1;

      if (|btn_edge)
        idle_next = 8'd0;
      else if (tick_reg && !any_held && idle_reg != 8'hFF)
        idle_next = idle_reg + 8'd1;

      // An edit pulse shows the field and restarts the blink phase from visible
      if (|(inc_next | dec_next))
        blink_next = 1'b1;
      else if (tick_reg)
        blink_next = ~blink_reg;
    end

    if (state_next != state_reg) begin
      hold_next = 4'd0;
      if (state_next == RUN) blink_next = 1'b0;
      else                   idle_next  = 8'd0;
    end

    field_sel_next  = state_next;
    set_active_next = (state_next != RUN);
  end

  assign count_en   = count_en_reg;
  assign inc_pulse  = inc_reg;
  assign dec_pulse  = dec_reg;
  assign field_sel  = field_sel_reg;
  assign set_active = set_active_reg;
  assign blink      = blink_reg;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: run counting, mode stepping, edits,
// auto-repeat, collisions, timeout, blink and mid-edit reset.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, btn_mode, btn_up, btn_down;
  logic       count_en, set_active, blink;
  logic [2:0] inc_pulse, dec_pulse;
  logic [1:0] field_sel;

  int checks = 0;
  int errors = 0;

  // Output event counters sampled on the falling edge
  int ce_cnt = 0, ce_set_cnt = 0, inc_h = 0, inc_m = 0, dec_m = 0, dec_h = 0;
  int base_a, base_b;
  int exp_sel [4] = '{1, 2, 3, 0};

  always #5 clk = ~clk;

  clock_set_controller #(
    .TIMEOUT_TICKS(3),
    .REPEAT_DELAY (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .count_en  (count_en),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .field_sel (field_sel),
    .set_active(set_active),
    .blink     (blink)
  );

  always @(negedge clk) begin
    if (count_en) ce_cnt++;
    if (count_en && set_active) ce_set_cnt++;
    if (inc_pulse == 3'b100) inc_h++;
    if (inc_pulse == 3'b010) inc_m++;
    if (dec_pulse == 3'b010) dec_m++;
    if (dec_pulse == 3'b100) dec_h++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(2);
    btn_mode = 1'b0;
    step(2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    step(3);
    check("rst_field_sel", field_sel, 0);
    check("rst_set_active", set_active, 0);
    check("rst_count_en", count_en, 0);
    check("rst_inc", inc_pulse, 0);
    check("rst_dec", dec_pulse, 0);
    check("rst_blink", blink, 0);
    rst = 1'b0;
    step(1);

    // RUN: five ticks, each count_en one cycle wide and one cycle late
    base_a = ce_cnt;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check("run_ce_latency", count_en, 0);
      step(1);
      check("run_ce_pulse", count_en, 1);
      step(1);
      check("run_ce_width", count_en, 0);
    end
    check("run_ce_total", ce_cnt - base_a, 5);
    check("run_no_edit", inc_h + inc_m + dec_m + dec_h, 0);
    check("run_field_sel", field_sel, 0);

    // Mode stepping 1,2,3,0 with a tick in each set state
    base_a = ce_cnt;
    for (int i = 0; i < 4; i++) begin
      btn_mode = 1'b1;
      step(1);
      check("mode_latency", field_sel, (i == 0) ? 0 : exp_sel[i-1]);
      step(1);
      check("mode_field_sel", field_sel, exp_sel[i]);
      check("mode_set_active", set_active, (exp_sel[i] != 0) ? 1 : 0);
      btn_mode = 1'b0;
      step(2);
      if (exp_sel[i] != 0) begin
        do_tick();
        step(1);
        check("set_ce_frozen", count_en, 0);
        step(1);
      end
    end
    check("set_ce_total", ce_cnt - base_a, 0);
    check("ce_with_set", ce_set_cnt, 0);

    // SET_MIN: three ups and one down
    press_mode();
    press_mode();
    check("min_field_sel", field_sel, 2);
    base_a = inc_m;
    base_b = dec_m;
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      step(1);
      check("min_up_latency", inc_pulse, 0);
      step(1);
      check("min_up_pulse", inc_pulse, 3'b010);
      check("min_up_blink", blink, 1);
      btn_up = 1'b0;
      step(1);
      check("min_up_width", inc_pulse, 0);
      step(1);
    end
    btn_down = 1'b1;
    step(2);
    check("min_down_pulse", dec_pulse, 3'b010);
    check("min_down_no_inc", inc_pulse, 0);
    btn_down = 1'b0;
    step(1);
    check("min_down_width", dec_pulse, 0);
    step(1);
    check("min_inc_total", inc_m - base_a, 3);
    check("min_dec_total", dec_m - base_b, 1);

    // SET_HOUR: hold up across six ticks, repeat from tick 3 on
    press_mode();
    press_mode();
    press_mode();
    check("hour_field_sel", field_sel, 1);
    base_a = inc_h;
    btn_up = 1'b1;
    step(3);
    for (int i = 0; i < 6; i++) begin
      do_tick();
      step(1);
      check("hour_repeat", inc_pulse, (i >= 2) ? 3'b100 : 3'b000);
      step(2);
    end
    btn_up = 1'b0;
    step(2);
    check("hour_inc_total", inc_h - base_a, 5);
    check("hour_no_timeout", field_sel, 1);

    // Mode and up edges together: mode wins, no pulse
    base_a = inc_h + inc_m;
    btn_mode = 1'b1;
    btn_up = 1'b1;
    step(2);
    check("mode_wins_field", field_sel, 2);
    check("mode_wins_inc", inc_pulse, 0);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    step(2);
    check("mode_wins_total", inc_h + inc_m - base_a, 0);

    // SET_SEC idle timeout after third tick
    press_mode();
    check("sec_field_sel", field_sel, 3);
    check("sec_blink_pre", blink, 1);
    do_tick();
    step(3);
    check("sec_blink_t1", blink, 0);
    do_tick();
    step(3);
    check("sec_blink_t2", blink, 1);
    check("sec_before_timeout", field_sel, 3);
    do_tick();
    check("timeout_latency", field_sel, 3);
    step(1);
    check("timeout_field_sel", field_sel, 0);
    check("timeout_set_active", set_active, 0);
    check("timeout_blink", blink, 0);
    step(2);

    // Holding down blocks the timeout; repeat decrements hour
    press_mode();
    base_a = dec_h;
    btn_down = 1'b1;
    step(3);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      step(3);
    end
    check("hold_no_timeout", field_sel, 1);
    check("hold_dec_total", dec_h - base_a, 4);
    btn_down = 1'b0;
    step(2);

    // Reset mid-repeat in SET_MIN
    press_mode();
    check("rr_field_sel", field_sel, 2);
    btn_up = 1'b1;
    step(3);
    do_tick();
    step(3);
    do_tick();
    step(3);
    btn_up = 1'b0;
    tick_1hz = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tick_1hz = 1'b0;
    check("rr_field_sel_rst", field_sel, 0);
    check("rr_set_active", set_active, 0);
    check("rr_inc", inc_pulse, 0);
    check("rr_count_en", count_en, 0);
    check("rr_blink", blink, 0);
    step(1);
    check("rr_no_repeat", inc_pulse, 0);
    check("rr_no_stale_ce", count_en, 0);
    do_tick();
    step(1);
    check("rr_ce_after", count_en, 1);
    check("rr_inc_after", inc_pulse, 0);
    check("rr_dec_after", dec_pulse, 0);
    check("rr_field_after", field_sel, 0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
